// File: rtl/approx_err_accum.sv
// Error-statistics accumulator for an approximate multiplier.
// Each accepted sample carries the operands and the approximate product.
// Stage 1 registers the exact product next to the approximate one.
// Stage 2 forms the absolute error distance and folds it into the statistics.
// The run controller counts acceptances and, once the last sample is taken,
// drains the pipeline before it raises done.
module approx_err_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           num_samples,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in1,
  input  logic [WIDTH-1:0]           in2,
  input  logic [2*WIDTH-1:0]         approx_prod,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           err_count,
  output logic [2*WIDTH+CNT_W-1:0]   sum_ed,
  output logic [2*WIDTH-1:0]         max_ed
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic [1:0]       drain_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             launch;

  logic             s1_valid_q;
  logic [PW-1:0]    s1_exact_q;
  logic [PW-1:0]    s1_approx_q;

  logic [PW-1:0]    ed;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;

  // in_ready is only ever high in RUN, so acceptance implies RUN.
  assign accept = in_valid && in_ready_q;
  // start is honoured only from IDLE or DONE; RUN and DRAIN ignore it.
  assign launch = start && ((state_q == IDLE) || (state_q == DONE));
  assign acc_d  = acc_q + CNT_W'(1);

  // Run controller: latches the sample budget, gates in_ready, drains the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      acc_q      <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_q   <= num_samples;
            acc_q   <= '0;
            drain_q <= '0;
            if (num_samples != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end else begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_q <= acc_d;
            if (acc_d == num_q) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Three drain edges after the final acceptance edge: the last
          // sample clears both stages before done is raised.
          if (drain_q == 2'd2) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture exact and approximate products of each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q  <= PW'(in1) * PW'(in2);
        s1_approx_q <= approx_prod;
      end
    end
  end

  // Stage 2 next-state: error distance and statistics update, cleared on a new run.
  always_comb begin
    ed    = (s1_approx_q >= s1_exact_q) ? (s1_approx_q - s1_exact_q)
                                        : (s1_exact_q - s1_approx_q);
    err_d = err_q;
    sum_d = sum_q;
    max_d = max_q;
    if (launch) begin
      err_d = '0;
      sum_d = '0;
      max_d = '0;
    end else if (s1_valid_q) begin
      if (ed != '0) begin
        err_d = err_q + CNT_W'(1);
      end
      sum_d = sum_q + SW'(ed);
      if (ed > max_q) begin
        max_d = ed;
      end
    end
  end

  // Stage 2 registers: statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else begin
      err_q <= err_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_q;

endmodule

// File: doc/approx_err_accum.md
APPROX_ERR_ACCUM -- requirements
Module: approx_err_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width of the multiplier under test.
REQ-002 SHALL have parameter CNT_W, default 16, width of sample and error counters.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a measurement run.
REQ-006 SHALL have port num_samples  input  CNT_W  samples to accept in the run, sampled on start.
REQ-007 SHALL have port in_valid  input  1  upstream sample valid.
REQ-008 SHALL have port in_ready  output  1  block accepts the sample this cycle.
REQ-009 SHALL have port in1  input  WIDTH  multiplier operand A.
REQ-010 SHALL have port in2  input  WIDTH  multiplier operand B.
REQ-011 SHALL have port approx_prod  input  2*WIDTH  DUT result {overflow,out}.
REQ-012 SHALL have port busy  output  1  run in progress.
REQ-013 SHALL have port done  output  1  statistics final; held until next start or reset.
REQ-014 SHALL have port err_count  output  CNT_W  samples with nonzero error distance.
REQ-015 SHALL have port sum_ed  output  2*WIDTH+CNT_W  sum of error distances.
REQ-016 SHALL have port max_ed  output  2*WIDTH  largest error distance seen.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL move IDLE->RUN on start when num_samples != 0; IDLE->DONE on start when num_samples == 0, with all statistics zero.
REQ-019 SHALL drive in_ready = 1 only in RUN while accepted < latched num_samples; a sample is accepted when in_valid && in_ready.
REQ-020 SHALL move RUN->DRAIN on the cycle the last sample is accepted; DRAIN->DONE after 2 cycles, so done rises 3 edges after the final acceptance edge.
REQ-021 SHALL pipeline in 2 stages: stage 1 registers exact = in1*in2 (unsigned, 2*WIDTH bits) and approx_prod; stage 2 computes ed = |approx - exact| and updates statistics.
REQ-022 SHALL, per accepted sample: sum_ed += ed; max_ed = max(max_ed, ed); err_count += 1 if ed != 0.
REQ-023 SHALL never overflow sum_ed (width covers (2^CNT_W - 1) * (2^(2*WIDTH) - 1)); no saturation logic.
REQ-024 SHALL ignore start in RUN and DRAIN.
REQ-025 SHALL, on start in DONE, clear all statistics and done and re-enter RUN (or DONE if num_samples == 0) as in REQ-018.
REQ-026 SHALL assert busy in RUN and DRAIN only.
REQ-027 SHALL tolerate in_valid gaps; pipeline stages advance only with valid data (bubbles do not update statistics).
REQ-028 SHALL ignore in1, in2, approx_prod when no acceptance occurs.

Reset
REQ-029 SHALL, on rst, enter IDLE asynchronously; busy, done, in_ready = 0; err_count, sum_ed, max_ed = 0; pipeline valid bits = 0.
REQ-030 SHALL, on rst mid-run, discard all in-flight samples; no statistics from the aborted run survive.

Verification
REQ-031 Bench SHALL check: start, num_samples=1, sample in1=2, in2=4, approx_prod=8 -> done 3 edges after acceptance, err_count=0, sum_ed=0, max_ed=0.
REQ-032 Bench SHALL check: num_samples=3, samples (3,3,10),(5,5,20),(7,1,7) -> err_count=2, sum_ed=6, max_ed=5.
REQ-033 Bench SHALL check: num_samples=0 -> done next cycle, busy never high, in_ready never high, stats zero.
REQ-034 Bench SHALL check: num_samples=2 with in_valid held high for 5 cycles -> exactly 2 acceptances, in_ready low afterwards; a start pulse during DRAIN is ignored.
REQ-035 Bench SHALL check: rst asserted after 1 of 4 samples -> all outputs 0 immediately; a new run with (255,255,0) -> sum_ed=65025, max_ed=65025, err_count=1.
